seq_add_multiplier: RTL and testbench

- Unsigned multiplier built from a controller FSM and a register datapath; the product is formed by repeated addition.
- Operands arrive one after the other on a shared input bus: multiplicand A first, then multiplier B.
- Accumulator P adds A once per cycle while B counts down to zero.
- Used as a small, area-cheap multiply unit, with a start/done handshake, wherever throughput is not critical.

---
 rtl/mul_pkg.sv | 15 +
 rtl/mul_dp.sv | 97 +++++++++
 rtl/seq_add_multiplier.sv | 91 +++++++++
 tb/tb_seq_add_multiplier.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential add-and-accumulate multiplier.
package mul_pkg;

   localparam int unsigned MUL_WIDTH_DEF = 16;

   // Controller states: capture A, capture B, accumulate, then hold the result.
   typedef enum logic [2:0] {
      StIdle,
      StLoadA,
      StLoadB,
      StCalc,
      StDone
   } mul_state_e;

endpackage

// File: rtl/mul_dp.sv
// Multiplier datapath: A operand register, B down-counter, P accumulator and B==0 detect.
// Optional carry-out tracking is built only when MUL_OVF_DETECT_EN is defined.
module mul_dp
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ld_a_i,
   input  logic             ld_b_i,
   input  logic             clr_p_i,
   input  logic             ld_p_i,
   input  logic             dec_b_i,
   output logic             eqz_o,
`ifdef MUL_OVF_DETECT_EN
   output logic             ovf_o,
`endif
   output logic [WIDTH-1:0] product_o
);

   localparam logic [WIDTH-1:0] OneW = WIDTH'(1);

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] p_sum;

`ifdef MUL_OVF_DETECT_EN
   logic             ovf_q, ovf_d;
   logic [WIDTH:0]   sum_wide;
   logic             carry;

   // Widened add so the carry out of the top bit is visible.
   assign sum_wide = {1'b0, p_q} + {1'b0, a_q};
   assign p_sum    = sum_wide[WIDTH-1:0];
   assign carry    = sum_wide[WIDTH];
   assign ovf_o    = ovf_q;
`else
   // Product wraps modulo 2^WIDTH; the carry is discarded.
   assign p_sum = p_q + a_q;
`endif

   assign eqz_o     = (b_q == '0);
   assign product_o = p_q;

   // Next-state selection for the operand, counter and accumulator registers.
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      p_d = p_q;
      if (ld_a_i) a_d = data_i;
      if (ld_b_i) begin
         b_d = data_i;
      end else if (dec_b_i) begin
         b_d = b_q - OneW;
      end
      if (clr_p_i) begin
         p_d = '0;
      end else if (ld_p_i) begin
         p_d = p_sum;
      end
   end

`ifdef MUL_OVF_DETECT_EN
   // Overflow is sticky across the accumulation and cleared with P.
   always_comb begin
      ovf_d = ovf_q;
      if (clr_p_i) begin
         ovf_d = 1'b0;
      end else if (ld_p_i && carry) begin
         ovf_d = 1'b1;
      end
   end

   // Overflow flag register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) ovf_q <= 1'b0;
      else       ovf_q <= ovf_d;
   end
`endif

   // Datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_q <= '0;
         b_q <= '0;
         p_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         p_q <= p_d;
      end
   end

endmodule

// File: rtl/seq_add_multiplier.sv
// Sequential unsigned multiplier: controller FSM around mul_dp, product formed by repeated
// addition of A while B counts down. Defining MUL_OVF_DETECT_EN adds a sticky ovf output.
module seq_add_multiplier
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic             done,
`ifdef MUL_OVF_DETECT_EN
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] product
);

   mul_state_e state_q, state_d;

   logic ld_a;
   logic ld_b;
   logic clr_p;
   logic ld_p;
   logic dec_b;
   logic eqz;

   // State register; reset aborts any operation in progress.
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Next state and datapath controls, decoded from the registered state only.
   always_comb begin
      state_d = state_q;
      ld_a    = 1'b0;
      ld_b    = 1'b0;
      clr_p   = 1'b0;
      ld_p    = 1'b0;
      dec_b   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StLoadA;
         end
         StLoadA: begin
            ld_a    = 1'b1;
            state_d = StLoadB;
         end
         StLoadB: begin
            ld_b    = 1'b1;
            clr_p   = 1'b1;
            state_d = StCalc;
         end
         StCalc: begin
            if (eqz) begin
               state_d = StDone;
            end else begin
               ld_p  = 1'b1;
               dec_b = 1'b1;
            end
         end
         StDone: begin
            // No automatic restart: start must drop before a new operation.
            if (!start) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign done = (state_q == StDone);

   mul_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk_i     (clk),
      .rst_i     (rst),
      .data_i    (data_in),
      .ld_a_i    (ld_a),
      .ld_b_i    (ld_b),
      .clr_p_i   (clr_p),
      .ld_p_i    (ld_p),
      .dec_b_i   (dec_b),
      .eqz_o     (eqz),
`ifdef MUL_OVF_DETECT_EN
      .ovf_o     (ovf),
`endif
      .product_o (product)
   );

endmodule

// File: tb/tb_seq_add_multiplier.sv
// Bench for seq_add_multiplier: transaction-level model checked every cycle, plus directed
// literal expectations for the documented multiply cases.
module tb_seq_add_multiplier;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] data_in;
   logic         done;
   logic [W-1:0] product;
`ifdef MUL_OVF_DETECT_EN
   logic         ovf;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   seq_add_multiplier #(
      .WIDTH (W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .data_in (data_in),
      .done    (done),
`ifdef MUL_OVF_DETECT_EN
      .ovf     (ovf),
`endif
      .product (product)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction model: an accepted start captures A one edge later, B two edges later, and
   // the result appears 3+B edges after acceptance as the low W bits of A*B.
   bit     m_busy = 1'b0;
   bit     m_done = 1'b0;
   bit     m_pv   = 1'b0;
   bit     m_ovf  = 1'b0;
   int     m_n    = 0;
   longint m_a    = 0;
   longint m_b    = 0;
   longint m_prod = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_prod = 0;
         m_pv   = 1'b1;
         m_ovf  = 1'b0;
      end else if (m_busy) begin
         m_n++;
         if (m_n == 1) begin
            m_a = longint'(data_in);
         end else if (m_n == 2) begin
            m_b  = longint'(data_in);
            m_pv = 1'b0;
         end
         if (m_n >= 2 && longint'(m_n) == 3 + m_b) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_prod = (m_a * m_b) % (64'd1 << W);
            m_ovf  = (m_a * m_b) >= (64'd1 << W);
            m_pv   = 1'b1;
         end
      end else if (m_done) begin
         if (!start) m_done = 1'b0;
      end else if (start) begin
         m_busy = 1'b1;
         m_n    = 0;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("done", 64'(done), 64'(m_done));
         if (m_pv) check("product", 64'(product), 64'(m_prod));
`ifdef MUL_OVF_DETECT_EN
         if (m_done) check("ovf", 64'(ovf), 64'(m_ovf));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one multiply and wait for done; lat is the edge count after the accepting edge.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      start = 1'b1;
      tick();
      data_in = a;
      tick();
      data_in = b;
      tick();
      data_in = W'($urandom);
      lat = 2;
      while (!done && lat < int'(b) + 10) begin
         tick();
         data_in = W'($urandom);
         lat++;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: done not seen, got 0, expected 1 (a=%0d b=%0d)", a, b);
      end
   endtask

   int lat;

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      data_in = '0;
      tick();
      tick();
      rst    = 1'b0;
      chk_en = 1'b1;
      check("reset_done", 64'(done), 64'd0);
      check("reset_product", 64'(product), 64'd0);
      tick();

      // 17 x 5, then hold start in DONE.
      run_op(16'd17, 16'd5, lat);
      check("lat_17x5", 64'(lat), 64'd8);
      check("prod_17x5", 64'(product), 64'd85);
`ifdef MUL_OVF_DETECT_EN
      check("ovf_17x5", 64'(ovf), 64'd0);
`endif
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_done", 64'(done), 64'd1);
         check("hold_prod", 64'(product), 64'd85);
      end
      start = 1'b0;
      tick();
      check("drop_done", 64'(done), 64'd0);
      check("drop_prod", 64'(product), 64'd85);

      // 3 x 4 after the handshake.
      run_op(16'd3, 16'd4, lat);
      check("lat_3x4", 64'(lat), 64'd7);
      check("prod_3x4", 64'(product), 64'd12);
      start = 1'b0;
      tick();

      // B = 0: no accumulation cycles.
      run_op(16'd9, 16'd0, lat);
      check("lat_9x0", 64'(lat), 64'd3);
      check("prod_9x0", 64'(product), 64'd0);
      start = 1'b0;
      tick();

      // Wrapping product.
      run_op(16'd300, 16'd300, lat);
      check("prod_300x300", 64'(product), 64'd24464);
`ifdef MUL_OVF_DETECT_EN
      check("ovf_300x300", 64'(ovf), 64'd1);
`endif
      start = 1'b0;
      tick();

      // Reset after two accumulation edges of 17 x 5.
      start = 1'b1;
      tick();
      data_in = 16'd17;
      tick();
      data_in = 16'd5;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_done", 64'(done), 64'd0);
      check("abort_prod", 64'(product), 64'd0);
      tick();

      run_op(16'd6, 16'd7, lat);
      check("prod_6x7", 64'(product), 64'd42);
      start = 1'b0;
      tick();

      // A = 0 with the largest B.
      run_op(16'd0, 16'd65535, lat);
      check("lat_0x65535", 64'(lat), 64'd65538);
      check("prod_0x65535", 64'(product), 64'd0);
      start = 1'b0;
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
